// File: rtl/fwd_hazard_ctrl_pkg.sv
// Shared types for the forwarding / load-use hazard controller.
// Build option FWD_HAZARD_FORWARDING_EN selects forwarding vs. stall-only operation.
package fwd_hazard_ctrl_pkg;
  localparam int NB_REG = 5;
  localparam int NB_SEL = 2;

  localparam logic [NB_SEL-1:0] FWD_REG = 2'b00;
  localparam logic [NB_SEL-1:0] FWD_WB  = 2'b01;
  localparam logic [NB_SEL-1:0] FWD_MEM = 2'b10;

  typedef struct packed {
    logic              valid;
    logic [NB_REG-1:0] dest;
    logic              reg_write;
    logic              mem_read;
  } trk_t;

  typedef enum logic {RUN = 1'b0, STALL = 1'b1} state_e;

  // $0 is hard-wired zero, so it never creates a dependency
  function automatic logic trk_match(trk_t s, logic [NB_REG-1:0] src, logic use_src);
    return s.valid & s.reg_write & (s.dest == src) & (src != '0) & use_src;
  endfunction
endpackage

// File: rtl/fwd_src_sel.sv
// Select and hazard logic for one EX operand source (rs or rt).
// FWD_HAZARD_FORWARDING_EN enables forwarding; otherwise any dependency stalls.
module fwd_src_sel
  import fwd_hazard_ctrl_pkg::*;
(
  input  logic [NB_REG-1:0] src_i,
  input  logic              use_i,
  input  logic              id_valid_i,
  input  trk_t              ex_i,
  input  trk_t              mem_i,
  output logic [NB_SEL-1:0] sel_o,
  output logic              hazard_o
);
  logic match_ex, match_mem;

  assign match_ex  = trk_match(ex_i, src_i, use_i);
  assign match_mem = trk_match(mem_i, src_i, use_i);

`ifdef FWD_HAZARD_FORWARDING_EN
  logic unused_mem_rd;
  assign unused_mem_rd = mem_i.mem_read;

  // Load data is not ready until MEM completes; everything else bypasses.
  assign hazard_o = match_ex & ex_i.mem_read & id_valid_i;
  assign sel_o    = (match_ex & ~ex_i.mem_read) ? FWD_MEM :
                    match_mem                   ? FWD_WB  : FWD_REG;
`else
  logic unused_rd;
  assign unused_rd = ex_i.mem_read ^ mem_i.mem_read;

  assign hazard_o = (match_ex | match_mem) & id_valid_i;
  assign sel_o    = FWD_REG;
`endif
endmodule

// File: rtl/fwd_hazard_ctrl.sv
// Forwarding and load-use hazard controller for the 5-stage pipeline.
// FWD_HAZARD_FORWARDING_EN enables operand forwarding; undefined = stall until WB.
module fwd_hazard_ctrl
  import fwd_hazard_ctrl_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              id_valid_i,
  input  logic [NB_REG-1:0] id_rs_i,
  input  logic [NB_REG-1:0] id_rt_i,
  input  logic              id_use_rs_i,
  input  logic              id_use_rt_i,
  input  logic [NB_REG-1:0] id_dest_i,
  input  logic              id_reg_write_i,
  input  logic              id_mem_read_i,
  input  logic              flush_i,
  output logic [NB_SEL-1:0] fwd_a_sel_o,
  output logic [NB_SEL-1:0] fwd_b_sel_o,
  output logic              stall_o,
  output logic              bubble_o,
  output logic              ex_valid_o
);
  trk_t              ex_q, mem_q, wb_q, ex_d;
  state_e            state_q;
  logic [NB_SEL-1:0] sel_rs, sel_rt, fwd_a_q, fwd_b_q;
  logic              haz_rs, haz_rt, hazard, advance;
  logic              unused_wb;

  fwd_src_sel u_sel_rs (
    .src_i      (id_rs_i),
    .use_i      (id_use_rs_i),
    .id_valid_i (id_valid_i),
    .ex_i       (ex_q),
    .mem_i      (mem_q),
    .sel_o      (sel_rs),
    .hazard_o   (haz_rs)
  );

  fwd_src_sel u_sel_rt (
    .src_i      (id_rt_i),
    .use_i      (id_use_rt_i),
    .id_valid_i (id_valid_i),
    .ex_i       (ex_q),
    .mem_i      (mem_q),
    .sel_o      (sel_rt),
    .hazard_o   (haz_rt)
  );

  // Flush kills the ID instruction, so its hazard no longer matters.
  assign hazard   = haz_rs | haz_rt;
  assign stall_o  = hazard & ~flush_i;
  assign bubble_o = stall_o | flush_i;
  assign advance  = id_valid_i & ~stall_o & ~flush_i;

  always_comb begin
    ex_d = '0;
    if (advance) begin
      ex_d.valid     = 1'b1;
      ex_d.dest      = id_dest_i;
      ex_d.reg_write = id_reg_write_i;
      ex_d.mem_read  = id_mem_read_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      ex_q    <= '0;
      mem_q   <= '0;
      wb_q    <= '0;
      fwd_a_q <= FWD_REG;
      fwd_b_q <= FWD_REG;
      state_q <= RUN;
    end else begin
      ex_q    <= ex_d;
      mem_q   <= ex_q;
      wb_q    <= mem_q;
      fwd_a_q <= advance ? sel_rs : FWD_REG;
      fwd_b_q <= advance ? sel_rt : FWD_REG;
      case (state_q)
        RUN:     state_q <= stall_o ? STALL : RUN;
`ifdef FWD_HAZARD_FORWARDING_EN
        STALL:   state_q <= RUN;
`else
        STALL:   state_q <= stall_o ? STALL : RUN;
`endif
        default: state_q <= RUN;
      endcase
    end
  end

  // WB is tracked for completeness; the write-through regfile needs no bypass from it.
  assign unused_wb = ^wb_q;

  assign fwd_a_sel_o = fwd_a_q;
  assign fwd_b_sel_o = fwd_b_q;
  assign ex_valid_o  = ex_q.valid;
endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Directed table-driven bench for fwd_hazard_ctrl (both FWD_HAZARD_FORWARDING_EN builds).
module tb_fwd_hazard_ctrl;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       id_valid, use_rs, use_rt, reg_write, mem_read, flush;
  logic [4:0] rs, rt, dest;
  logic [1:0] sel_a, sel_b;
  logic       stall, bubble, ex_valid;

  int n_chk = 0;
  int n_err = 0;

  typedef struct {
    logic       v;
    logic [4:0] rs, rt;
    logic       urs, urt;
    logic [4:0] dest;
    logic       rw, mr, fl;
    logic [1:0] ea, eb;
    logic       st, bu, ev;
  } vec_t;

  vec_t tbl[$];

  fwd_hazard_ctrl dut (
    .clk_i          (clk),
    .rst_n_i        (rst_n),
    .id_valid_i     (id_valid),
    .id_rs_i        (rs),
    .id_rt_i        (rt),
    .id_use_rs_i    (use_rs),
    .id_use_rt_i    (use_rt),
    .id_dest_i      (dest),
    .id_reg_write_i (reg_write),
    .id_mem_read_i  (mem_read),
    .flush_i        (flush),
    .fwd_a_sel_o    (sel_a),
    .fwd_b_sel_o    (sel_b),
    .stall_o        (stall),
    .bubble_o       (bubble),
    .ex_valid_o     (ex_valid)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(int v, int s, int t, int us, int ut, int d, int w, int m,
                              int f, int ea, int eb, int st, int bu, int ev);
    vec_t x;
    x.v = 1'(v); x.rs = 5'(s); x.rt = 5'(t); x.urs = 1'(us); x.urt = 1'(ut);
    x.dest = 5'(d); x.rw = 1'(w); x.mr = 1'(m); x.fl = 1'(f);
    x.ea = 2'(ea); x.eb = 2'(eb); x.st = 1'(st); x.bu = 1'(bu); x.ev = 1'(ev);
    return x;
  endfunction

  function automatic vec_t ins(int s, int t, int d, int w, int m, int f,
                               int ea, int eb, int st, int bu, int ev);
    return mk(1, s, t, 1, 1, d, w, m, f, ea, eb, st, bu, ev);
  endfunction

  function automatic vec_t nop(int ea, int eb, int ev);
    return mk(0, 0, 0, 1, 1, 0, 0, 0, 0, ea, eb, 0, 0, ev);
  endfunction

  task automatic drive(vec_t x);
    id_valid = x.v; rs = x.rs; rt = x.rt; use_rs = x.urs; use_rt = x.urt;
    dest = x.dest; reg_write = x.rw; mem_read = x.mr; flush = x.fl;
  endtask

  task automatic chk(string nm, int idx, logic [1:0] act, logic [1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s row %0d: got %0d want %0d", nm, idx, act, exp);
    end
  endtask

  task automatic chk_all(int idx, logic [1:0] ea, logic [1:0] eb, logic st, logic bu, logic ev);
    chk("fwd_a_sel", idx, sel_a, ea);
    chk("fwd_b_sel", idx, sel_b, eb);
    chk("stall", idx, {1'b0, stall}, {1'b0, st});
    chk("bubble", idx, {1'b0, bubble}, {1'b0, bu});
    chk("ex_valid", idx, {1'b0, ex_valid}, {1'b0, ev});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl.push_back(nop(0, 0, 0));
`ifdef FWD_HAZARD_FORWARDING_EN
    // add $3 ; add $4,$3,$5 -> EX bypass on A
    tbl.push_back(ins(1, 2, 3, 1, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(ins(3, 5, 4, 1, 0, 0, 0, 0, 0, 0, 1));
    tbl.push_back(nop(2, 0, 1));
    tbl.push_back(nop(0, 0, 0)); tbl.push_back(nop(0, 0, 0));
    // add $3 ; nop ; sub $6,$5,$3 -> MEM bypass on B
    tbl.push_back(ins(1, 2, 3, 1, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(nop(0, 0, 1));
    tbl.push_back(ins(5, 3, 6, 1, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(nop(0, 1, 1));
    tbl.push_back(nop(0, 0, 0)); tbl.push_back(nop(0, 0, 0));
    // lw $7 ; add $8,$7,$7 -> one stall, then both from WB
    tbl.push_back(ins(1, 0, 7, 1, 1, 0, 0, 0, 0, 0, 0));
    tbl.push_back(ins(7, 7, 8, 1, 0, 0, 0, 0, 1, 1, 1));
    tbl.push_back(ins(7, 7, 8, 1, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(nop(1, 1, 1));
    tbl.push_back(nop(0, 0, 0)); tbl.push_back(nop(0, 0, 0));
    // two producers of $3: youngest (EX) wins
    tbl.push_back(ins(1, 2, 3, 1, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(ins(4, 5, 3, 1, 0, 0, 0, 0, 0, 0, 1));
    tbl.push_back(ins(3, 3, 4, 1, 0, 0, 0, 0, 0, 0, 1));
    tbl.push_back(nop(2, 2, 1));
    tbl.push_back(nop(0, 0, 0)); tbl.push_back(nop(0, 0, 0));
`else
    // add $3 ; add $4,$3,$5 -> two stall cycles, selects stay 00
    tbl.push_back(ins(1, 2, 3, 1, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(ins(3, 5, 4, 1, 0, 0, 0, 0, 1, 1, 1));
    tbl.push_back(ins(3, 5, 4, 1, 0, 0, 0, 0, 1, 1, 0));
    tbl.push_back(ins(3, 5, 4, 1, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(nop(0, 0, 1));
    tbl.push_back(nop(0, 0, 0)); tbl.push_back(nop(0, 0, 0));
    // add $3 ; nop ; sub $6,$5,$3 -> one stall while producer in MEM
    tbl.push_back(ins(1, 2, 3, 1, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(nop(0, 0, 1));
    tbl.push_back(ins(5, 3, 6, 1, 0, 0, 0, 0, 1, 1, 0));
    tbl.push_back(ins(5, 3, 6, 1, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(nop(0, 0, 1));
    tbl.push_back(nop(0, 0, 0)); tbl.push_back(nop(0, 0, 0));
    // lw $7 ; add $8,$7,$7 -> two stalls
    tbl.push_back(ins(1, 0, 7, 1, 1, 0, 0, 0, 0, 0, 0));
    tbl.push_back(ins(7, 7, 8, 1, 0, 0, 0, 0, 1, 1, 1));
    tbl.push_back(ins(7, 7, 8, 1, 0, 0, 0, 0, 1, 1, 0));
    tbl.push_back(ins(7, 7, 8, 1, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(nop(0, 0, 1));
    tbl.push_back(nop(0, 0, 0)); tbl.push_back(nop(0, 0, 0));
    // two producers of $3: stall tracks the younger one
    tbl.push_back(ins(1, 2, 3, 1, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(ins(4, 5, 3, 1, 0, 0, 0, 0, 0, 0, 1));
    tbl.push_back(ins(3, 3, 4, 1, 0, 0, 0, 0, 1, 1, 1));
    tbl.push_back(ins(3, 3, 4, 1, 0, 0, 0, 0, 1, 1, 0));
    tbl.push_back(ins(3, 3, 4, 1, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(nop(0, 0, 1));
    tbl.push_back(nop(0, 0, 0)); tbl.push_back(nop(0, 0, 0));
`endif
    // $0 producer then $0 reader -> nothing
    tbl.push_back(ins(1, 2, 0, 1, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(ins(0, 0, 9, 1, 0, 0, 0, 0, 0, 0, 1));
    tbl.push_back(nop(0, 0, 1));
    tbl.push_back(nop(0, 0, 0)); tbl.push_back(nop(0, 0, 0));
    // addi with rt field = $5 but rt not read -> no dependency
    tbl.push_back(ins(1, 2, 5, 1, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 1, 5, 1, 0, 6, 1, 0, 0, 0, 0, 0, 0, 1));
    tbl.push_back(nop(0, 0, 1));
    tbl.push_back(nop(0, 0, 0)); tbl.push_back(nop(0, 0, 0));
    // lw $7 ; dependent add flushed -> bubble without stall
    tbl.push_back(ins(1, 0, 7, 1, 1, 0, 0, 0, 0, 0, 0));
    tbl.push_back(ins(7, 7, 8, 1, 0, 1, 0, 0, 0, 1, 1));
    tbl.push_back(nop(0, 0, 0));
    tbl.push_back(nop(0, 0, 0)); tbl.push_back(nop(0, 0, 0));
    // store (no reg write) writing dest field $3 -> no dependency
    tbl.push_back(ins(1, 3, 3, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(ins(3, 3, 4, 1, 0, 0, 0, 0, 0, 0, 1));
    tbl.push_back(nop(0, 0, 1));
    tbl.push_back(nop(0, 0, 0)); tbl.push_back(nop(0, 0, 0));

    rst_n = 1'b0;
    drive(nop(0, 0, 0));
    repeat (2) @(negedge clk);
    chk_all(-1, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;

    foreach (tbl[i]) begin
      @(posedge clk); #1;
      drive(tbl[i]);
      @(negedge clk);
      chk_all(i, tbl[i].ea, tbl[i].eb, tbl[i].st, tbl[i].bu, tbl[i].ev);
    end

    // reset asserted mid-stall aborts it at once
    @(posedge clk); #1;
    drive(ins(1, 0, 7, 1, 1, 0, 0, 0, 0, 0, 0));
    @(posedge clk); #1;
    drive(ins(7, 7, 8, 1, 0, 0, 0, 0, 0, 0, 0));
    @(negedge clk);
    chk_all(900, 2'b00, 2'b00, 1'b1, 1'b1, 1'b1);
    #1 rst_n = 1'b0;
    #1 chk_all(901, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    chk_all(902, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
    drive(nop(0, 0, 0));
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
